// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath /
// ALU control decoder. The master side is the controller.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic       jmorsig;
  logic       aluop3;
  logic       aluop2;
  logic       aluop1;
  logic       aluop0;
  logic       pcwrite;
  logic [1:0] pcsrc;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       regwrite;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zext;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, sign, jmorsig,
    output aluop3, aluop2, aluop1, aluop0, pcwrite, pcsrc, iord, memread,
           memwrite, irwrite, regdst, regwrite, memtoreg, alusrca, alusrcb,
           zext, instr_done, illegal, state
  );

  modport slave (
    output op, zero, sign, jmorsig,
    input  aluop3, aluop2, aluop1, aluop0, pcwrite, pcsrc, iord, memread,
           memwrite, irwrite, regdst, regwrite, memtoreg, alusrca, alusrcb,
           zext, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALUOp plus every datapath select and write strobe.
module multicycle_ctrl #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_BLEZ = 6'b000110,
  parameter logic [5:0] OP_ANDI = 6'b001100
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    BLEZ   = 4'd9,
    ANDIEX = 4'd10,
    ANDIWB = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       jmor_q, jmor_d;
  logic [3:0] aluop;
  logic       pcwrite;
  logic [1:0] pcsrc;
  logic       iord, memread, memwrite, irwrite;
  logic       regdst, regwrite, memtoreg, alusrca;
  logic [1:0] alusrcb;
  logic       zext, instr_done, illegal;

  // jmor_q remembers whether the R-type in flight was a jmor so RWB can
  // redirect the PC instead of writing the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      jmor_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      jmor_q  <= jmor_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    jmor_d     = jmor_q;
    aluop      = 4'b0000;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zext       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        aluop   = 4'b1000;
        pcwrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluop   = 4'b1000;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = REXEC;
          OP_BEQ:       state_d = BEQ;
          OP_BLEZ:      state_d = BLEZ;
          OP_ANDI:      state_d = ANDIEX;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 4'b1000;
        state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
      end
      REXEC: begin
        alusrca = 1'b1;
        aluop   = 4'b0010;
        jmor_d  = bus.jmorsig;
        state_d = RWB;
      end
      RWB: begin
        instr_done = 1'b1;
        jmor_d     = 1'b0;
        if (jmor_q) begin
          pcwrite = 1'b1;
          pcsrc   = 2'b10;
        end else begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
      end
      BEQ: begin
        alusrca    = 1'b1;
        aluop      = 4'b0001;
        pcsrc      = 2'b01;
        pcwrite    = bus.zero;
        instr_done = 1'b1;
      end
      BLEZ: begin
        alusrca    = 1'b1;
        aluop      = 4'b0101;
        pcsrc      = 2'b01;
        pcwrite    = bus.zero | bus.sign;
        instr_done = 1'b1;
      end
      ANDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zext    = 1'b1;
        aluop   = 4'b0100;
        state_d = ANDIWB;
      end
      ANDIWB: begin
        regwrite   = 1'b1;
        zext       = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset blanks every output immediately, even before the state register
  // has been forced back to FETCH.
  assign bus.aluop3     = ~reset & aluop[3];
  assign bus.aluop2     = ~reset & aluop[2];
  assign bus.aluop1     = ~reset & aluop[1];
  assign bus.aluop0     = ~reset & aluop[0];
  assign bus.pcwrite    = ~reset & pcwrite;
  assign bus.pcsrc      = reset ? 2'b00 : pcsrc;
  assign bus.iord       = ~reset & iord;
  assign bus.memread    = ~reset & memread;
  assign bus.memwrite   = ~reset & memwrite;
  assign bus.irwrite    = ~reset & irwrite;
  assign bus.regdst     = ~reset & regdst;
  assign bus.regwrite   = ~reset & regwrite;
  assign bus.memtoreg   = ~reset & memtoreg;
  assign bus.alusrca    = ~reset & alusrca;
  assign bus.alusrcb    = reset ? 2'b00 : alusrcb;
  assign bus.zext       = ~reset & zext;
  assign bus.instr_done = ~reset & instr_done;
  assign bus.illegal    = ~reset & illegal;
  assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model is checked
// every cycle, plus hand-computed latencies and final-state strobe vectors.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  // Vector layout: aluop[19:16] pcwrite[15] pcsrc[14:13] iord[12] memread[11]
  // memwrite[10] irwrite[9] regdst[8] regwrite[7] memtoreg[6] alusrca[5]
  // alusrcb[4:3] zext[2] instr_done[1] illegal[0]
  localparam logic [19:0] V_FETCH = 20'h88A08;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] packOut();
    return {bus.aluop3, bus.aluop2, bus.aluop1, bus.aluop0, bus.pcwrite, bus.pcsrc,
            bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.regdst,
            bus.regwrite, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.zext,
            bus.instr_done, bus.illegal};
  endfunction

  // Expected strobes for a named phase of an instruction.
  function automatic logic [19:0] expOut(int s, logic z, logic sg, bit jm, logic [5:0] o);
    logic [3:0] alu;
    logic [1:0] pcs, asb;
    logic pcw, io, mr, mw, irw, rd, rw, m2r, asa, zx, dn, il;
    alu = 4'b0000; pcs = 2'b00; asb = 2'b00;
    pcw = 0; io = 0; mr = 0; mw = 0; irw = 0; rd = 0; rw = 0; m2r = 0;
    asa = 0; zx = 0; dn = 0; il = 0;
    case (s)
      0:  begin mr = 1; irw = 1; asb = 2'b01; alu = 4'b1000; pcw = 1; end
      1:  begin
            asb = 2'b11; alu = 4'b1000;
            if (!(o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BLEZ, OP_ANDI})) begin
              il = 1; dn = 1;
            end
          end
      2:  begin asa = 1; asb = 2'b10; alu = 4'b1000; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = 1; end
      6:  begin asa = 1; alu = 4'b0010; end
      7:  begin dn = 1; if (jm) begin pcw = 1; pcs = 2'b10; end else begin rw = 1; rd = 1; end end
      8:  begin asa = 1; alu = 4'b0001; pcs = 2'b01; pcw = z; dn = 1; end
      9:  begin asa = 1; alu = 4'b0101; pcs = 2'b01; pcw = z | sg; dn = 1; end
      10: begin asa = 1; asb = 2'b10; zx = 1; alu = 4'b0100; end
      11: begin rw = 1; zx = 1; dn = 1; end
      default: ;
    endcase
    return {alu, pcw, pcs, io, mr, mw, irw, rd, rw, m2r, asa, asb, zx, dn, il};
  endfunction

  // Instruction-level model: the phases still to run for the current
  // instruction are kept in a queue filled when the opcode becomes known.
  int  mstate = 0;
  bit  mjmor  = 0;
  int  mq[$];

  always @(negedge clk) begin
    checkOutput("outputs", {12'd0, packOut()},
                reset ? 32'd0 : {12'd0, expOut(mstate, bus.zero, bus.sign, mjmor, bus.op)});
    checkOutput("state", {28'd0, bus.state}, reset ? 32'd0 : mstate);
    if (reset) begin
      mstate = 0;
      mjmor  = 0;
      mq.delete();
    end else begin
      if (mstate == 1) begin
        mq.delete();
        case (bus.op)
          OP_LW, OP_SW: mq.push_back(2);
          OP_R:         begin mq.push_back(6); mq.push_back(7); end
          OP_BEQ:       mq.push_back(8);
          OP_BLEZ:      mq.push_back(9);
          OP_ANDI:      begin mq.push_back(10); mq.push_back(11); end
          default: ;
        endcase
      end
      if (mstate == 2) begin
        if (bus.op == OP_LW) begin mq.push_back(3); mq.push_back(4); end
        else mq.push_back(5);
      end
      if (mstate == 6) mjmor = bus.jmorsig;
      if (mstate == 7) mjmor = 0;
      if (mstate == 0) mstate = 1;
      else if (mq.size() > 0) mstate = mq.pop_front();
      else mstate = 0;
    end
  end

  // Runs one instruction from FETCH; checks its latency and the strobes of
  // its final (instr_done) cycle against hand-computed values.
  task automatic applyStimulus(input string name, input logic [5:0] o, input logic z,
                               input logic sg, input logic jm, input int expLat,
                               input logic [19:0] expDone);
    int cyc;
    logic [19:0] doneVec;
    bus.op = o; bus.zero = z; bus.sign = sg; bus.jmorsig = jm;
    cyc = 0;
    doneVec = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput({name, "_fetch"}, {12'd0, packOut()}, {12'd0, V_FETCH});
      if (bus.instr_done) begin
        cyc = i;
        doneVec = packOut();
        break;
      end
    end
    checkOutput({name, "_latency"}, cyc, expLat);
    checkOutput({name, "_final"}, {12'd0, doneVec}, {12'd0, expDone});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.op = OP_LW; bus.zero = 0; bus.sign = 0; bus.jmorsig = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {12'd0, packOut()}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus("lw",      OP_LW,   0, 0, 0, 5, 20'h000C2);
    applyStimulus("sw",      OP_SW,   0, 0, 0, 4, 20'h01402);
    applyStimulus("rtype",   OP_R,    0, 0, 0, 4, 20'h00182);
    applyStimulus("jmor",    OP_R,    0, 0, 1, 4, 20'h0C002);
    applyStimulus("blez_00", OP_BLEZ, 0, 0, 0, 3, 20'h52022);
    applyStimulus("blez_01", OP_BLEZ, 0, 1, 0, 3, 20'h5A022);
    applyStimulus("blez_10", OP_BLEZ, 1, 0, 0, 3, 20'h5A022);
    applyStimulus("beq_z1",  OP_BEQ,  1, 0, 0, 3, 20'h1A022);
    applyStimulus("beq_z0",  OP_BEQ,  0, 0, 0, 3, 20'h12022);
    applyStimulus("andi",    OP_ANDI, 0, 0, 0, 4, 20'h00086);
    applyStimulus("illegal", 6'b111111, 0, 0, 0, 2, 20'h8001B);

    // Abort a load in MEMRD with reset, then check the clean restart.
    bus.op = OP_LW; bus.zero = 0; bus.sign = 0; bus.jmorsig = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.state == 4'd3) break;
      @(posedge clk); #1;
    end
    checkOutput("reached_memrd", {28'd0, bus.state}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_memread", {31'd0, bus.memread}, 32'd0);
    checkOutput("abort_outputs", {12'd0, packOut()}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("restart_state", {28'd0, bus.state}, 32'd0);
    checkOutput("restart_fetch", {12'd0, packOut()}, {12'd0, V_FETCH});
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
